// File: rtl/branch_compare_seq.sv
// Slice-serial magnitude comparator for the RV32I branch path: one SLICE_W-bit
// compare per cycle, LSB slice first, producing gt/eq/lt and the branch-taken flag.
module branch_compare_seq #(
   parameter int DATA_W  = 32,
   parameter int SLICE_W = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [2:0]        i_funct3,
   input  logic              i_flush,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_gt,
   output logic              o_eq,
   output logic              o_lt,
   output logic              o_taken,
   output logic              o_err,
   output logic [1:0]        dbg_state
);

   localparam int NSLICE = DATA_W / SLICE_W;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Handshake: a request transfers on a rising edge with i_valid & o_ready;
   // a result transfers on a rising edge with o_valid & i_ready. o_valid and
   // the result fields stay stable until that transfer or a flush/reset.

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] a_sh;
   logic [DATA_W-1:0] b_sh;
   logic [2:0]        f3;
   logic              acc_gt;
   logic              acc_eq;
   logic              acc_lt;

   logic [DATA_W-1:0] sign_flip;
   logic [SLICE_W-1:0] slice_a;
   logic [SLICE_W-1:0] slice_b;
   logic              nxt_gt;
   logic              nxt_eq;
   logic              nxt_lt;
   logic              nxt_taken;
   logic              nxt_err;

   // Flipping both MSBs maps two's-complement order onto unsigned order.
   assign sign_flip = {~i_funct3[1], {(DATA_W-1){1'b0}}};

   // Operands are shifted down each RUN cycle so the active slice is always at bit 0.
   assign slice_a = a_sh[SLICE_W-1:0];
   assign slice_b = b_sh[SLICE_W-1:0];

   always_comb begin
      nxt_gt = acc_gt;
      nxt_eq = acc_eq;
      nxt_lt = acc_lt;
      if (slice_a > slice_b) begin
         nxt_gt = 1'b1;
         nxt_eq = 1'b0;
         nxt_lt = 1'b0;
      end else if (slice_a < slice_b) begin
         nxt_gt = 1'b0;
         nxt_eq = 1'b0;
         nxt_lt = 1'b1;
      end
   end

   always_comb begin
      nxt_taken = 1'b0;
      nxt_err   = 1'b0;
      case (f3)
         3'b000:         nxt_taken = nxt_eq;
         3'b001:         nxt_taken = ~nxt_eq;
         3'b100, 3'b110: nxt_taken = nxt_lt;
         3'b101, 3'b111: nxt_taken = ~nxt_lt;
         default:        nxt_err   = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         cnt     <= '0;
         a_sh    <= '0;
         b_sh    <= '0;
         f3      <= '0;
         acc_gt  <= 1'b0;
         acc_eq  <= 1'b1;
         acc_lt  <= 1'b0;
         o_ready <= 1'b1;
         o_valid <= 1'b0;
         o_gt    <= 1'b0;
         o_eq    <= 1'b0;
         o_lt    <= 1'b0;
         o_taken <= 1'b0;
         o_err   <= 1'b0;
      end else if (i_flush) begin
         state   <= IDLE;
         cnt     <= '0;
         o_ready <= 1'b1;
         o_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  a_sh    <= i_a ^ sign_flip;
                  b_sh    <= i_b ^ sign_flip;
                  f3      <= i_funct3;
                  acc_gt  <= 1'b0;
                  acc_eq  <= 1'b1;
                  acc_lt  <= 1'b0;
                  cnt     <= '0;
                  o_ready <= 1'b0;
                  state   <= RUN;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> SLICE_W;
               b_sh   <= b_sh >> SLICE_W;
               acc_gt <= nxt_gt;
               acc_eq <= nxt_eq;
               acc_lt <= nxt_lt;
               if (cnt == LAST_CNT) begin
                  cnt     <= '0;
                  o_gt    <= nxt_gt;
                  o_eq    <= nxt_eq;
                  o_lt    <= nxt_lt;
                  o_taken <= nxt_taken;
                  o_err   <= nxt_err;
                  o_valid <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  o_ready <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               o_ready <= 1'b1;
               o_valid <= 1'b0;
            end
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_branch_compare_seq.sv
// Bench for branch_compare_seq: directed cases, backpressure, flush/reset aborts
// and randomized operations checked against an arithmetic compare model.
module tb_branch_compare_seq;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic [2:0]  i_funct3;
   logic        i_flush;
   logic        o_valid;
   logic        i_ready;
   logic        o_gt;
   logic        o_eq;
   logic        o_lt;
   logic        o_taken;
   logic        o_err;
   logic [1:0]  dbg_state;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [4:0]  exp_q[$];

   always #5 i_clk = ~i_clk;

   branch_compare_seq #(.DATA_W(32), .SLICE_W(4)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_a       (i_a),
      .i_b       (i_b),
      .i_funct3  (i_funct3),
      .i_flush   (i_flush),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_gt      (o_gt),
      .o_eq      (o_eq),
      .o_lt      (o_lt),
      .o_taken   (o_taken),
      .o_err     (o_err),
      .dbg_state (dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: {gt, eq, lt, taken, err} from plain signed/unsigned arithmetic.
   function automatic logic [4:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f);
      logic gt, eq, lt, taken, err;
      if (f[1] == 1'b0) begin
         gt = $signed(a) > $signed(b);
         lt = $signed(a) < $signed(b);
      end else begin
         gt = a > b;
         lt = a < b;
      end
      eq    = (a == b);
      err   = (f == 3'b010) || (f == 3'b011);
      case (f)
         3'b000:         taken = eq;
         3'b001:         taken = !eq;
         3'b100, 3'b110: taken = lt;
         3'b101, 3'b111: taken = !lt;
         default:        taken = 1'b0;
      endcase
      return {gt, eq, lt, taken, err};
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check_fields(input string tag, input logic [4:0] e);
      check({tag, "_gt"},    o_gt,    e[4]);
      check({tag, "_eq"},    o_eq,    e[3]);
      check({tag, "_lt"},    o_lt,    e[2]);
      check({tag, "_taken"}, o_taken, e[1]);
      check({tag, "_err"},   o_err,   e[0]);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ready"}, o_ready, 1'b1);
      check({tag, "_valid"}, o_valid, 1'b0);
      check_fields(tag, 5'b00000);
   endtask

   task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
      check("ready_before_accept", o_ready, 1'b1);
      i_a      = a;
      i_b      = b;
      i_funct3 = f;
      i_valid  = 1'b1;
      exp_q.push_back(model(a, b, f));
      tick();
      i_valid  = 1'b0;
      // Scramble operands: changes after the accept edge must not matter.
      i_a      = $urandom;
      i_b      = $urandom;
      i_funct3 = 3'($urandom_range(0, 7));
      check("ready_busy", o_ready, 1'b0);
   endtask

   task automatic wait_result(input string tag);
      int lat;
      lat = 0;
      while (!o_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, 8);
      check_fields(tag, exp_q[0]);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input int hold);
      accept(a, b, f);
      wait_result(tag);
      for (int k = 0; k < hold; k++) begin
         i_valid = 1'($urandom_range(0, 1));
         tick();
         check({tag, "_hold_valid"}, o_valid, 1'b1);
         check({tag, "_hold_ready"}, o_ready, 1'b0);
         check_fields({tag, "_hold"}, exp_q[0]);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check({tag, "_consumed_valid"}, o_valid, 1'b0);
      check({tag, "_consumed_ready"}, o_ready, 1'b1);
      void'(exp_q.pop_front());
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [2:0]  rf;
      int          sel;

      i_rst = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0; i_funct3 = '0;
      i_flush = 1'b0; i_ready = 1'b0;
      repeat (2) tick();
      check_reset_state("reset");
      i_rst = 1'b0;
      tick();
      check_reset_state("post_reset");

      run_op("bltu_u",   32'h8000_0000, 32'h0000_0001, 3'b110, 0);
      run_op("blt_s",    32'h8000_0000, 32'h0000_0001, 3'b100, 0);
      run_op("bge_low",  32'h1234_5679, 32'h1234_5678, 3'b101, 0);
      run_op("beq_eq",   32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b000, 0);
      run_op("bne_eq",   32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b001, 0);
      run_op("err_010",  32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b010, 0);
      run_op("err_011",  32'h0000_0001, 32'hFFFF_FFFF, 3'b011, 0);
      run_op("backpres", 32'h7FFF_FFFF, 32'h8000_0000, 3'b101, 5);

      // Flush at RUN cycle 4: no result must appear.
      accept(32'h0000_0005, 32'h0000_0003, 3'b110);
      repeat (3) tick();
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      check("flush_ready", o_ready, 1'b1);
      check("flush_valid", o_valid, 1'b0);
      void'(exp_q.pop_front());
      repeat (10) begin
         tick();
         check("flush_quiet", o_valid, 1'b0);
      end
      run_op("after_flush", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'b100, 1);

      // Flush beats a simultaneous request in IDLE.
      i_valid = 1'b1; i_flush = 1'b1; i_a = 32'h1; i_b = 32'h2; i_funct3 = 3'b110;
      tick();
      i_valid = 1'b0; i_flush = 1'b0;
      check("flush_idle_ready", o_ready, 1'b1);
      repeat (10) tick();
      check("flush_idle_valid", o_valid, 1'b0);

      // Reset while a result is held clears everything.
      accept(32'hFFFF_FFFF, 32'h0000_0000, 3'b111);
      wait_result("pre_reset");
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check_reset_state("reset_done");
      void'(exp_q.pop_front());
      run_op("after_reset", 32'h0000_0010, 32'h0000_0100, 3'b111, 0);

      for (int n = 0; n < 40; n++) begin
         ra  = $urandom;
         sel = $urandom_range(0, 3);
         if (sel == 0)      rb = ra;
         else if (sel == 1) rb = ra ^ (32'hF << (4 * $urandom_range(0, 7)));
         else if (sel == 2) rb = ra ^ 32'h8000_0000;
         else               rb = $urandom;
         rf = 3'($urandom_range(0, 7));
         run_op($sformatf("rand%0d", n), ra, rb, rf, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
